// File: rtl/regfile_write_bank.sv
// -----------------------------------------------------------------------------
// regfile_write_bank
//
// Write side of the 32-entry register file. It holds 32 registers of N bits,
// decodes the 5-bit write index into a one-hot strobe, and exposes the whole
// bank as a flat bus that the existing 32:1 read muxes slice. A bulk-clear
// engine zeroes the bank one entry per cycle. While it runs, writes are held
// off through wr_ready.
//
// Parameters
//   N         width of each register
//   ZERO_REG  1: register 0 is hardwired to zero and writes to it are dropped
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-low reset
//   wr_ena     write request
//   wr_addr    write register index 0..31
//   wr_data    write data
//   wr_ready   a write can be accepted this cycle
//   clr_start  request a bulk clear of all 32 registers
//   busy       bulk clear in progress (registered)
//   wr_strobe  one-hot decode of the write accepted this cycle
//   regs       flat register contents; register k is at [k*N +: N]
// -----------------------------------------------------------------------------
module regfile_write_bank #(
    parameter int N        = 32,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_ena,
    input  logic [4:0]        wr_addr,
    input  logic [N-1:0]      wr_data,
    output logic              wr_ready,
    input  logic              clr_start,
    output logic              busy,
    output logic [31:0]       wr_strobe,
    output logic [32*N-1:0]   regs
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t         state_r;
    logic [4:0]     cnt_r;
    logic           busy_r;
    logic [N-1:0]   regs_r [32];

    logic           wr_accept_s;
    logic           wr_discard_s;

    // Write handshake. wr_ready drops during reset so that a request held
    // across reset is not counted as accepted.
    always_comb begin
        wr_ready     = 1'b0;
        wr_accept_s  = 1'b0;
        wr_discard_s = 1'b0;
        wr_strobe    = 32'd0;
        if (rst && (state_r == IDLE)) begin
            wr_ready = 1'b1;
        end else begin
            wr_ready = 1'b0;
        end
        wr_accept_s = wr_ena & wr_ready;
        if (wr_accept_s) begin
            // The strobe still fires for a dropped write to register 0.
            wr_strobe = 32'd1 << wr_addr;
        end else begin
            wr_strobe = 32'd0;
        end
        if ((ZERO_REG == 1) && (wr_addr == 5'd0)) begin
            wr_discard_s = 1'b1;
        end else begin
            wr_discard_s = 1'b0;
        end
    end

    // Register bank, clear sequencer and busy flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
            cnt_r   <= 5'd0;
            busy_r  <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= {N{1'b0}};
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (wr_accept_s && !wr_discard_s) begin
                        regs_r[wr_addr] <= wr_data;
                    end
                    // A write on the same edge lands first; the sweep
                    // reaches that register later and zeroes it.
                    if (clr_start) begin
                        state_r <= CLEAR;
                        cnt_r   <= 5'd0;
                        busy_r  <= 1'b1;
                    end
                end
                CLEAR: begin
                    // clr_start is ignored here: no restart, no extension.
                    regs_r[cnt_r] <= {N{1'b0}};
                    cnt_r         <= cnt_r + 5'd1;
                    if (cnt_r == 5'd31) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= 5'd0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_r;

    // Flatten the bank for the read muxes.
    for (genvar k = 0; k < 32; k++) begin : g_flat
        assign regs[k*N +: N] = regs_r[k];
    end

endmodule

// File: tb/tb_regfile_write_bank.sv
// -----------------------------------------------------------------------------
// tb_regfile_write_bank
//
// Directed bench for regfile_write_bank (N=32, ZERO_REG=1). It keeps an
// expected copy of the bank (exp_m) and compares every slice of regs with it
// around each write and on every cycle of each clear sweep.
// -----------------------------------------------------------------------------
module tb_regfile_write_bank;

    logic           clk;
    logic           rst;
    logic           wr_ena;
    logic [4:0]     wr_addr;
    logic [31:0]    wr_data;
    logic           wr_ready;
    logic           clr_start;
    logic           busy;
    logic [31:0]    wr_strobe;
    logic [1023:0]  regs;

    logic [31:0]    exp_m [32];
    int             checks;
    int             failures;

    regfile_write_bank #(.N(32), .ZERO_REG(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_ena    (wr_ena),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .clr_start (clr_start),
        .busy      (busy),
        .wr_strobe (wr_strobe),
        .regs      (regs)
    );

    // 10 time-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 32; k++) begin
            check_eq($sformatf("reg%0d", k), regs[k*32 +: 32], exp_m[k]);
        end
    endtask

    // Called #1 after a posedge. Drives one write and checks strobe, the
    // absence of write-through, and one-cycle visibility.
    task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [31:0] exp_strobe);
        wr_ena  = 1'b1;
        wr_addr = a;
        wr_data = d;
        #1;
        check_eq("wr_ready_before_write", {31'd0, wr_ready}, 32'd1);
        check_eq($sformatf("strobe_addr%0d", a), wr_strobe, exp_strobe);
        check_all();
        @(posedge clk);
        #1;
        wr_ena = 1'b0;
        if (a != 5'd0) begin
            exp_m[a] = d;
        end
        check_all();
    endtask

    // Called #1 after the clear start edge. Walks n sweep cycles, trying a
    // blocked write at cycles 2..4 and a second clr_start at cycle 8.
    task automatic sweep(input int n);
        for (int c = 0; c < n; c++) begin
            if (c > 0) begin
                exp_m[c-1] = 32'd0;
            end
            check_eq($sformatf("busy_c%0d", c), {31'd0, busy}, 32'd1);
            check_eq($sformatf("ready_c%0d", c), {31'd0, wr_ready}, 32'd0);
            check_all();
            clr_start = (c == 8);
            if (c >= 2 && c <= 4) begin
                wr_ena  = 1'b1;
                wr_addr = 5'd3;
                wr_data = 32'h0000_00AA;
                #1;
                check_eq("blocked_strobe", wr_strobe, 32'd0);
            end else begin
                wr_ena = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        wr_ena      = 1'b0;
        clr_start   = 1'b0;
        exp_m[n-1]  = 32'd0;
        if (n == 32) begin
            check_eq("busy_after_sweep", {31'd0, busy}, 32'd0);
            check_eq("ready_after_sweep", {31'd0, wr_ready}, 32'd1);
        end else begin
            check_eq("busy_mid_sweep", {31'd0, busy}, 32'd1);
        end
        check_all();
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b0;
        wr_ena    = 1'b1;
        wr_addr   = 5'd5;
        wr_data   = 32'h1111_1111;
        clr_start = 1'b0;
        for (int k = 0; k < 32; k++) exp_m[k] = 32'd0;

        // Reset: request held during reset must not be taken.
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_ready", {31'd0, wr_ready}, 32'd0);
        check_eq("reset_strobe", wr_strobe, 32'd0);
        check_eq("reset_busy", {31'd0, busy}, 32'd0);
        check_all();
        wr_ena = 1'b0;
        rst    = 1'b1;
        #1;
        check_eq("ready_after_release", {31'd0, wr_ready}, 32'd1);

        // Register 0 is hardwired to zero.
        do_write(5'd0, 32'hDEAD_BEEF, 32'h0000_0001);

        // Back-to-back writes and decode.
        do_write(5'd5,  32'h1234_5678, 32'h0000_0020);
        do_write(5'd31, 32'hFFFF_FFFF, 32'h8000_0000);

        // Fill with index+1, then bulk clear.
        for (int k = 0; k < 32; k++) begin
            do_write(5'(k), 32'(k + 1), 32'd1 << k);
        end
        clr_start = 1'b1;
        #1;
        check_eq("ready_at_start", {31'd0, wr_ready}, 32'd1);
        @(posedge clk);
        #1;
        clr_start = 1'b0;
        sweep(32);

        // Simultaneous write and start.
        wr_ena    = 1'b1;
        wr_addr   = 5'd7;
        wr_data   = 32'h0000_0055;
        clr_start = 1'b1;
        #1;
        check_eq("simul_strobe", wr_strobe, 32'h0000_0080);
        @(posedge clk);
        #1;
        wr_ena    = 1'b0;
        clr_start = 1'b0;
        exp_m[7]  = 32'h0000_0055;
        sweep(32);

        // Reset mid-clear at sweep index 10.
        do_write(5'd20, 32'h0000_0077, 32'h0010_0000);
        do_write(5'd11, 32'h0000_0099, 32'h0000_0800);
        clr_start = 1'b1;
        @(posedge clk);
        #1;
        clr_start = 1'b0;
        sweep(10);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 32; k++) exp_m[k] = 32'd0;
        check_eq("abort_busy", {31'd0, busy}, 32'd0);
        check_eq("abort_ready_in_reset", {31'd0, wr_ready}, 32'd0);
        check_all();
        rst = 1'b1;
        #1;
        check_eq("abort_ready_released", {31'd0, wr_ready}, 32'd1);
        do_write(5'd12, 32'hC0DE_0012, 32'h0000_1000);
        @(posedge clk);
        #1;
        check_eq("idle_after_abort", {31'd0, busy}, 32'd0);
        check_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_write_bank.md
Name: regfile_write_bank

Overview:
- Write side of the 32-entry register file: 32 registers of N bits, with a 5-to-32 one-hot write-address decoder.
- The full register contents are presented as a flat bus. The existing 32:1 read muxes slice this bus for the read ports.
- A sequenced bulk-clear engine zeroes the bank one entry per cycle, with a busy/ready handshake toward the writer.

Parameters:
- N, 32, width in bits of each register.
- ZERO_REG, 1:
  - When 1, register 0 is hardwired to zero and writes to it are discarded.
  - When 0, register 0 is an ordinary register.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous, active-low: rst==0 at a rising clk edge resets the block.
- wr_ena  input  1  write request.
- wr_addr  input  5  write register index, 0..31.
- wr_data  input  N  write data.
- wr_ready  output  1  block can accept a write this cycle.
- clr_start  input  1  request a bulk clear of all 32 registers.
- busy  output  1  bulk clear in progress.
- wr_strobe  output  32  one-hot decode of the write being accepted this cycle.
- regs  output  32*N  flat register contents; register k occupies bits [k*N +: N].

Behaviour:
- One clock domain (clk). Reset is synchronous and active-low on rst.
- Reset (rst==0 at a posedge):
  - All 32 registers go to 0; state goes to IDLE; busy=0; clear counter=0.
  - While rst==0, wr_ready=0 and wr_strobe=0.
- wr_ready is combinational: rst==1 AND state==IDLE.
- Write accept: wr_ena==1 AND wr_ready==1 at a posedge.
  - regs[wr_addr] <= wr_data.
  - If ZERO_REG==1 and wr_addr==0, the write is discarded and register 0 stays 0.
  - Latency: the new value is visible on regs in the cycle after the accepting edge. There is no combinational write-through.
- wr_strobe is combinational: (1 << wr_addr) when a write is accepted, otherwise all-zero.
  - The strobe bit still asserts for a discarded write to register 0.
  - At most one bit is high at any time.
- wr_ena while wr_ready==0 has no effect: no register change, wr_strobe=0. The writer must hold its request until wr_ready==1.
- FSM states are IDLE and CLEAR.
  - IDLE -> CLEAR when clr_start==1 at a posedge. The clear counter is loaded with 0 on that edge.
  - In CLEAR, each posedge zeroes regs[counter] and increments counter (5-bit).
  - CLEAR -> IDLE on the edge that zeroes register 31. The counter wraps to 0.
  - busy is registered and equals (state==CLEAR). It is high for exactly 32 cycles per clear.
- Simultaneous wr_ena and clr_start in IDLE:
  - The write is accepted on that edge, and the clear starts on the same edge.
  - The written register is later zeroed when the sweep reaches it.
- clr_start while in CLEAR is ignored; there is no restart and no extension.
- rst==0 mid-clear aborts the sweep: state IDLE, all registers 0, counter 0.
- During CLEAR, registers not yet swept keep their old values on regs, so the read ports see a partially cleared bank.
- A write and a clear-sweep targeting the same register on the same edge cannot occur, because writes are blocked in CLEAR.

Test Plan:
- Reset and ZERO_REG:
  - Stimulus: hold rst=0 for 2 cycles, release, write wr_addr=0, wr_data=32'hDEADBEEF.
  - Required: regs all 0 after reset; wr_ready=1 after release; wr_strobe=32'h1 during the write; regs[0] stays 0.
- Write latency and decode:
  - Stimulus: write addr 5 = 32'h12345678, then addr 31 = 32'hFFFFFFFF on consecutive cycles.
  - Required: wr_strobe = 32'h20 then 32'h80000000; each value is visible on regs one cycle after its edge; other slices are unchanged.
- Bulk clear:
  - Stimulus: fill all 32 registers with value = index+1, then pulse clr_start one cycle.
  - Required: busy=1 and wr_ready=0 for exactly 32 cycles; register k reads 0 from cycle k+1 after the start edge; busy=0 afterward.
- Blocked writes:
  - Stimulus: during CLEAR, drive wr_ena=1, addr 3, data 32'hAA.
  - Required: wr_strobe=0; regs[3] is 0 after the sweep and never 32'hAA.
- Simultaneous start:
  - Stimulus: in IDLE, drive wr_ena (addr 7, data 32'h55) and clr_start on the same edge.
  - Required: regs[7]=32'h55 until the sweep reaches index 7, then 0; a second clr_start mid-sweep does not lengthen busy beyond 32 cycles.
- Reset mid-clear:
  - Stimulus: assert rst=0 at sweep index 10.
  - Required: next cycle busy=0 and all regs are 0; after release, wr_ready=1 and a write to addr 12 succeeds.
